// File: rtl/uart_tx_controller.sv
// uart_tx_controller: serialises one DBIT-wide byte per frame (start, data LSB first, stop), paced by s_tick; UART_TX_PARITY_EN adds an even-parity bit.
// Latency: tx drops 1 clk after accept; each bit edge follows its terminating s_tick by 1 clk; tx_done pulses with the return to idle.
// Backpressure: tx_ready is low from accept until the frame ends; upstream holds tx_valid/tx_data until it rises.
module uart_tx_controller #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16,
    parameter int OVS     = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            s_tick,
    input  logic            tx_valid,
    input  logic [DBIT-1:0] tx_data,
    output logic            tx_ready,
    output logic            tx_done,
    output logic            tx_busy,
    output logic            tx
);

    localparam int S_MAX = (OVS > SB_TICK) ? OVS : SB_TICK;
    localparam int SW    = (S_MAX > 1) ? $clog2(S_MAX) : 1;
    localparam int NW    = (DBIT > 1) ? $clog2(DBIT) : 1;

    localparam logic [SW-1:0] S_BIT_LAST  = SW'(OVS - 1);
    localparam logic [SW-1:0] S_STOP_LAST = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST      = NW'(DBIT - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_STOP   = 3'd3,
        ST_PARITY = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   s_q, s_d;
    logic [NW-1:0]   n_q, n_d;
    logic [DBIT-1:0] shreg_q, shreg_d;
    logic            done_q, done_d;
    logic            tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
    logic            par_q, par_d;
`endif

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        shreg_d = shreg_q;
        done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            ST_IDLE: begin
                // Ticks are ignored here, so a tick coincident with accept never counts.
                if (tx_valid) begin
                    state_d = ST_START;
                    s_d     = '0;
                    shreg_d = tx_data;
`ifdef UART_TX_PARITY_EN
                    par_d   = ^tx_data;
`endif
                end
            end
            ST_START: begin
                if (s_tick) begin
                    if (s_q == S_BIT_LAST) begin
                        state_d = ST_DATA;
                        s_d     = '0;
                        n_d     = '0;
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            ST_DATA: begin
                if (s_tick) begin
                    if (s_q == S_BIT_LAST) begin
                        shreg_d = shreg_q >> 1;
                        s_d     = '0;
                        if (n_q == N_LAST) begin
`ifdef UART_TX_PARITY_EN
                            state_d = ST_PARITY;
`else
                            state_d = ST_STOP;
`endif
                        end else begin
                            n_d = n_q + NW'(1);
                        end
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (s_tick) begin
                    if (s_q == S_BIT_LAST) begin
                        state_d = ST_STOP;
                        s_d     = '0;
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
`endif
            ST_STOP: begin
                if (s_tick) begin
                    if (s_q == S_STOP_LAST) begin
                        state_d = ST_IDLE;
                        s_d     = '0;
                        done_d  = 1'b1;
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                s_d     = '0;
                n_d     = '0;
                shreg_d = '0;
            end
        endcase

        // Line level is decoded from the next state so every edge lands with its state change.
        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shreg_d[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx_d = par_d;
`endif
            default:   tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            s_q     <= '0;
            n_q     <= '0;
            shreg_q <= '0;
            done_q  <= 1'b0;
            tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            shreg_q <= shreg_d;
            done_q  <= done_d;
            tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign tx_ready = (state_q == ST_IDLE);
    assign tx_busy  = ~tx_ready;
    assign tx_done  = done_q;
    assign tx       = tx_q;

endmodule

// File: doc/uart_tx_controller.md
Name: uart_tx_controller

Overview:
- Transmit-side sequencer for the UART that consumes the single-cycle oversampling tick from the baud-rate generator and serialises one byte per frame onto the line.
- Frame format is 8N1 by default: start bit, DBIT data bits LSB first, stop period.
- Upstream logic writes bytes through a valid/ready handshake.
- Sits between the baud-rate generator and the TX pad.

Parameters:
- DBIT, 8, number of data bits per frame (legal 5..8).
- SB_TICK, 16, stop period length in s_tick pulses (16 = 1 stop bit, 24 = 1.5, 32 = 2).
- OVS, 16, s_tick pulses per data/start bit (oversampling ratio; must match the generator, 100 MHz / (16 × 9600) → M = 651).

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- s_tick  input  1  one-clk-wide oversampling tick from the baud-rate generator.
- tx_valid  input  1  upstream byte available.
- tx_data  input  DBIT  byte to send, sampled on accept.
- tx_ready  output  1  controller idle and able to accept.
- tx_done  output  1  one-clk pulse at end of stop period.
- tx_busy  output  1  high from accept until the frame ends.
- tx  output  1  serial line, registered, idles high.

Behaviour:
- Reset (async, reset=0):
  - state=IDLE, tx=1, tx_ready=1, tx_busy=0, tx_done=0.
  - Tick counter, bit counter and shift register all cleared.
  - A reset mid-frame aborts the frame immediately; no partial stop bit is generated.
- Counters:
  - Tick counter s spans 0..max(OVS,SB_TICK)-1, with width $clog2 of that value.
  - Bit counter n spans 0..DBIT-1.
  - s advances only on clk edges where s_tick=1.
- IDLE:
  - tx=1, tx_ready=1.
  - Accept occurs when tx_valid && tx_ready: tx_data goes to the shift register, s=0, and the next state is START.
  - s_tick is ignored in IDLE, including a tick coincident with accept.
- START:
  - tx=0 from the first clk after accept.
  - On s_tick with s==OVS-1: s=0, n=0, go to DATA. Otherwise, on s_tick, s=s+1.
- DATA:
  - tx = shift register bit 0.
  - On s_tick with s==OVS-1: shift right by one, s=0. Then, if n==DBIT-1, go to STOP (or PARITY, see Optional Feature); otherwise n=n+1.
- STOP:
  - tx=1.
  - On s_tick with s==SB_TICK-1: tx_done=1 for exactly one clk, state goes to IDLE, and tx_ready rises in the same cycle the IDLE state is registered.
- Handshake:
  - tx_ready = (state==IDLE); tx_busy = !tx_ready.
  - tx_valid while busy is neither queued nor dropped silently; upstream must hold it until tx_ready.
  - A new byte may be accepted on the first IDLE cycle after tx_done, giving back-to-back frames with zero idle ticks.
- Timing:
  - Frame length is (1+DBIT)×OVS + SB_TICK ticks; the 8N1 default is 160 ticks.
  - Each bit edge on tx follows its terminating s_tick by 1 clk.
- s_tick on consecutive clocks (tests only) is legal: each pulse counts once.
- Unknown/illegal state encoding returns to IDLE with tx=1.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - Adds a PARITY state between DATA and STOP, lasting OVS ticks.
  - tx = even parity of the accepted byte: XOR of tx_data[DBIT-1:0], latched at accept.
  - Frame grows by OVS ticks (8E1 = 176 ticks).
- Undefined:
  - No PARITY state, no parity register; DATA goes directly to STOP.

Test Plan:
- Reset then idle: hold reset low 5 clk, release, run 1000 clk with tx_valid=0 → tx=1, tx_ready=1, tx_done never asserts.
- Single frame (OVS=16, tick every 4 clk): send 8'hA5 → tx sequence 0,1,0,1,0,0,1,0,1,1, each level 64 clk; tx_done pulses once, 640 clk (+1) after accept.
- Busy handshake: assert tx_valid=1 with 8'h3C during an active frame → tx_ready=0 and the byte is not taken; it is accepted on the first IDLE clk after tx_done and sent LSB-first.
- Back-to-back: keep tx_valid=1 with 8'h00 then 8'hFF → second start bit begins with no idle gap after the first stop period; two tx_done pulses exactly 160 ticks apart.
- Reset mid-frame: assert reset during data bit 3 of 8'h55 → tx=1 and tx_ready=1 immediately (asynchronous); after release, a new 8'h81 frame transmits correctly.
- With UART_TX_PARITY_EN: send 8'h07 → parity bit=1 and frame=176 ticks; send 8'h03 → parity bit=0.
